// File: rtl/uart_arb_pkg.sv
// ---------------------------------------------------------------------------
// uart_arb_pkg
// Shared definitions for the UART transmit arbiter and its round-robin picker.
//   arb_state_t  : arbiter FSM state encoding
//   SETTLE_CNT_W : width of the busy-settle counter (holds BUSY_SETTLE-1)
// ---------------------------------------------------------------------------
package uart_arb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ISSUE  = 2'd1,
        SETTLE = 2'd2,
        DRAIN  = 2'd3
    } arb_state_t;

    localparam int SETTLE_CNT_W = 4;

endpackage

// File: rtl/uart_tx_arbiter_rr_pick.sv
// ---------------------------------------------------------------------------
// rr_pick
// Combinational round-robin selector. The search starts one position after
// the last grant and wraps from NUM_REQ-1 back to 0.
// Ports:
//   req    [NUM_REQ] : request vector
//   last   [ID_W]    : index of the previous grant
//   winner [ID_W]    : chosen index (equals last when nothing is requested)
//   any              : at least one request bit is set
// ---------------------------------------------------------------------------
module rr_pick
    import uart_arb_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = 2
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [ID_W-1:0]    last,
    output logic [ID_W-1:0]    winner,
    output logic               any
);

    // Walk the candidates from the farthest to the nearest position after
    // 'last'; each hit overwrites the previous one, so the nearest request
    // in round-robin order ends up as the winner without a found flag.
    always_comb begin
        int idx;
        idx    = 0;
        winner = last;
        any    = |req;
        for (int off = NUM_REQ; off >= 1; off--) begin
            idx = (int'(last) + off) % NUM_REQ;
            if (req[idx]) begin
                winner = ID_W'(idx);
            end
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// ---------------------------------------------------------------------------
// uart_tx_arbiter
// Shares one buart transmitter between NUM_REQ byte-stream requesters using
// round-robin arbitration. Each accepted byte becomes a one-cycle write
// strobe; the arbiter then waits BUSY_SETTLE cycles for busy to rise and for
// busy to fall before it arbitrates again.
//
// Optional feature: define UART_ARB_PKT_LOCK_EN to keep the grant on one
// requester until it sends a byte flagged with req_last.
//
// Ports:
//   clk, reset       : clock, synchronous active-high reset
//   req_valid/ready  : per-requester handshake (ready is a one-hot pulse)
//   req_data         : byte of requester i in bits [8i+7:8i]
//   req_last         : end-of-packet flag (packet-lock builds only)
//   uart_wr          : write strobe to buart
//   uart_tx_data     : byte to buart
//   uart_busy        : busy from buart
//   grant_id         : current or last granted requester
//   grant_active     : high from ISSUE through DRAIN
// ---------------------------------------------------------------------------
module uart_tx_arbiter
    import uart_arb_pkg::*;
#(
    parameter int NUM_REQ     = 4,
    parameter int ID_W        = 2,
    parameter int BUSY_SETTLE = 2
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [NUM_REQ-1:0]   req_valid,
    input  logic [NUM_REQ*8-1:0] req_data,
    input  logic [NUM_REQ-1:0]   req_last,
    output logic [NUM_REQ-1:0]   req_ready,
    output logic                 uart_wr,
    output logic [7:0]           uart_tx_data,
    input  logic                 uart_busy,
    output logic [ID_W-1:0]      grant_id,
    output logic                 grant_active
);

    arb_state_t              state;
    arb_state_t              next_state;
    logic [SETTLE_CNT_W-1:0] settle_cnt;
    logic [NUM_REQ-1:0]      eligible;
    logic [ID_W-1:0]         pick_id;
    logic                    pick_any;
    logic [7:0]              sel_data;

`ifdef UART_ARB_PKT_LOCK_EN
    logic locked;

    // While a packet is open only its owner may be granted; the arbiter
    // waits for that requester no matter what the others present.
    always_comb begin
        eligible = req_valid;
        if (locked) begin
            eligible = req_valid & (NUM_REQ'(1) << grant_id);
        end
    end

    // The lock follows the req_last flag of the byte handed over in ISSUE.
    always_ff @(posedge clk) begin
        if (reset) begin
            locked <= 1'b0;
        end else if (state == ISSUE) begin
            locked <= ~|(req_last & req_ready);
        end
    end
`else
    logic unused_req_last;

    assign eligible        = req_valid;
    assign unused_req_last = ^req_last;
`endif

    rr_pick #(
        .NUM_REQ (NUM_REQ),
        .ID_W    (ID_W)
    ) u_pick (
        .req    (eligible),
        .last   (grant_id),
        .winner (pick_id),
        .any    (pick_any)
    );

    // Byte of the requester about to be granted.
    always_comb begin
        sel_data = 8'h00;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (pick_id == ID_W'(i)) begin
                sel_data = req_data[8*i +: 8];
            end
        end
    end

    // Next-state logic. Busy is ignored during SETTLE because buart raises it
    // a few cycles after wr; DRAIN only starts once that window has passed.
    // The counter is loaded with BUSY_SETTLE-1 and DRAIN is entered on the
    // cycle the counter reaches zero, so busy is first sampled BUSY_SETTLE
    // cycles after the write strobe.
    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (pick_any && !uart_busy) begin
                    next_state = ISSUE;
                end
            end
            ISSUE: begin
                next_state = SETTLE;
            end
            SETTLE: begin
                if (settle_cnt <= SETTLE_CNT_W'(1)) begin
                    next_state = DRAIN;
                end
            end
            DRAIN: begin
                if (!uart_busy) begin
                    next_state = IDLE;
                end
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    // State, counter and grant registers. The grant index and the byte are
    // captured on the IDLE->ISSUE edge so the UART sees stable data during wr.
    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            settle_cnt   <= '0;
            grant_id     <= ID_W'(NUM_REQ - 1);
            uart_tx_data <= 8'h00;
        end else begin
            state <= next_state;
            case (state)
                IDLE: begin
                    if (next_state == ISSUE) begin
                        grant_id     <= pick_id;
                        uart_tx_data <= sel_data;
                    end
                end
                ISSUE: begin
                    settle_cnt <= SETTLE_CNT_W'(BUSY_SETTLE - 1);
                end
                SETTLE: begin
                    if (settle_cnt != '0) begin
                        settle_cnt <= settle_cnt - 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Outputs come from registers only, never straight from an input.
    always_comb begin
        uart_wr      = (state == ISSUE);
        grant_active = (state != IDLE);
        req_ready    = uart_wr ? (NUM_REQ'(1) << grant_id) : '0;
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// ---------------------------------------------------------------------------
// tb_uart_tx_arbiter
// Drives the arbiter with per-requester byte queues and a stub busy line,
// predicting every output each cycle from a transaction-level reference:
// which requesters are eligible, who wins round-robin, and when the arbiter
// may look at requests again (BUSY_SETTLE cycles after a write, then busy
// low). Honours UART_ARB_PKT_LOCK_EN when it is defined for the build.
// ---------------------------------------------------------------------------
module tb_uart_tx_arbiter;

    localparam int NREQ = 4;
    localparam int IDW  = 2;
    localparam int BS   = 2;

`ifdef UART_ARB_PKT_LOCK_EN
    localparam bit LOCK_EN = 1'b1;
`else
    localparam bit LOCK_EN = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              reset;
    logic [NREQ-1:0]   req_valid;
    logic [NREQ*8-1:0] req_data;
    logic [NREQ-1:0]   req_last;
    logic [NREQ-1:0]   req_ready;
    logic              uart_wr;
    logic [7:0]        uart_tx_data;
    logic              uart_busy;
    logic [IDW-1:0]    grant_id;
    logic              grant_active;

    uart_tx_arbiter #(
        .NUM_REQ     (NREQ),
        .ID_W        (IDW),
        .BUSY_SETTLE (BS)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .req_valid    (req_valid),
        .req_data     (req_data),
        .req_last     (req_last),
        .req_ready    (req_ready),
        .uart_wr      (uart_wr),
        .uart_tx_data (uart_tx_data),
        .uart_busy    (uart_busy),
        .grant_id     (grant_id),
        .grant_active (grant_active)
    );

    always #5 clk = ~clk;

    // requester byte queues: {last, data}
    logic [8:0]      q [NREQ][$];
    logic [NREQ-1:0] gate;
    int              pop_w;
    bit              pop_stage;

    // stimulus controls
    bit drv_reset;
    bit ext_busy;
    int auto_len;
    bit rand_auto;
    int cyc;

    // reference model
    bit         m_idle;
    int         m_ptr;
    logic [7:0] m_data;
    bit         m_lock;
    int         m_issue;

    // observed writes
    int obs_id[$];
    int obs_cyc[$];
    int obs_data[$];

    int errors;
    int checks;

    task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s: observed=%0h expected=%0h cycle=%0d", tag, obs, exp, cyc);
        end
    endtask

    function automatic int at(input int qq[$], input int k);
        return (k < qq.size()) ? qq[k] : -1;
    endfunction

    function automatic int rr_expect(input logic [NREQ-1:0] elig, input int ptr);
        for (int k = 1; k <= NREQ; k++) begin
            if (elig[(ptr + k) % NREQ]) return (ptr + k) % NREQ;
        end
        return -1;
    endfunction

    // One clock: drive inputs, advance, update the reference, compare.
    task automatic apply_stimulus();
        logic [NREQ-1:0] v;
        logic [NREQ-1:0] elig;
        bit              b;
        bit              exp_wr;
        int              w;
        int              nxt;
        if (pop_w >= 0) begin
            if (pop_stage) begin
                q[pop_w].delete(0);
                pop_w = -1;
            end else begin
                pop_stage = 1'b1;
            end
        end
        for (int i = 0; i < NREQ; i++) begin
            if (q[i].size() > 0) begin
                req_data[8*i +: 8] = q[i][0][7:0];
                req_last[i]        = q[i][0][8];
                v[i]               = gate[i] || (pop_w == i);
            end else begin
                v[i] = 1'b0;
            end
        end
        nxt = cyc + 1;
        b = ext_busy || (auto_len > 0 && (nxt - m_issue) >= 2 && (nxt - m_issue) <= auto_len + 1);
        req_valid = v;
        uart_busy = b;
        reset     = drv_reset;
        @(posedge clk);
        cyc    = nxt;
        exp_wr = 1'b0;
        if (drv_reset) begin
            m_idle = 1'b1;
            m_ptr  = NREQ - 1;
            m_data = 8'h00;
            m_lock = 1'b0;
        end else if (m_idle) begin
            elig = v;
            if (m_lock) elig = v & (NREQ'(1) << m_ptr);
            w = rr_expect(elig, m_ptr);
            if (!b && w >= 0) begin
                exp_wr  = 1'b1;
                m_ptr   = w;
                m_data  = q[w][0][7:0];
                m_idle  = 1'b0;
                m_issue = cyc;
                if (LOCK_EN) m_lock = !q[w][0][8];
                pop_w     = w;
                pop_stage = 1'b0;
                if (rand_auto) auto_len = $urandom_range(0, 12);
            end
        end else if ((cyc - 1 - m_issue) >= BS && !b) begin
            m_idle = 1'b1;
        end
        #1;
        check_output("uart_wr", {31'b0, uart_wr}, {31'b0, exp_wr});
        check_output("req_ready", {28'b0, req_ready}, exp_wr ? (32'd1 << m_ptr) : 32'd0);
        check_output("grant_active", {31'b0, grant_active}, {31'b0, !m_idle});
        check_output("grant_id", {30'b0, grant_id}, m_ptr);
        check_output("uart_tx_data", {24'b0, uart_tx_data}, {24'b0, m_data});
        if (uart_wr === 1'b1) begin
            obs_id.push_back(int'(grant_id));
            obs_cyc.push_back(cyc);
            obs_data.push_back(int'(uart_tx_data));
        end
    endtask

    task automatic run_until(input int n, input int bound, input string tag);
        for (int k = 0; k < bound && obs_id.size() < n; k++) apply_stimulus();
        check_output(tag, obs_id.size(), n);
    endtask

    task automatic clear_obs();
        obs_id.delete();
        obs_cyc.delete();
        obs_data.delete();
    endtask

    task automatic pulse_reset();
        drv_reset = 1'b1;
        apply_stimulus();
        drv_reset = 1'b0;
        clear_obs();
    endtask

    initial begin
        int start;
        int exp_seq[$];
        errors = 0; checks = 0; cyc = 0;
        req_valid = '0; req_data = '0; req_last = '0; uart_busy = 1'b0; reset = 1'b1;
        gate = '0; pop_w = -1; pop_stage = 1'b0;
        drv_reset = 1'b1; ext_busy = 1'b0; auto_len = 0; rand_auto = 1'b0;
        m_idle = 1'b1; m_ptr = NREQ - 1; m_data = 8'h00; m_lock = 1'b0; m_issue = -1000;

        // reset values
        repeat (2) apply_stimulus();
        check_output("rst_grant_id", {30'b0, grant_id}, 3);
        check_output("rst_wr", {31'b0, uart_wr}, 0);
        check_output("rst_ready", {28'b0, req_ready}, 0);
        check_output("rst_tx_data", {24'b0, uart_tx_data}, 0);
        check_output("rst_active", {31'b0, grant_active}, 0);
        drv_reset = 1'b0;
        clear_obs();

        // single requester 2, byte AA, busy stub high for 20 cycles
        $display("[TB] single requester");
        auto_len = 20;
        q[2].push_back({1'b1, 8'hAA});
        gate[2] = 1'b1;
        start = cyc;
        run_until(1, 20, "a_timeout");
        repeat (40) apply_stimulus();
        check_output("a_count", obs_id.size(), 1);
        check_output("a_winner", at(obs_id, 0), 2);
        check_output("a_latency", at(obs_cyc, 0), start + 1);
        check_output("a_data", at(obs_data, 0), 32'hAA);
        gate = '0;

        // all four valid: rotation 0,1,2,3,0,1,2,3
        $display("[TB] all requesters");
        pulse_reset();
        auto_len = 8;
        for (int r = 0; r < 2; r++)
            for (int i = 0; i < NREQ; i++) q[i].push_back({1'b1, 8'(8'h10 + i)});
        gate = '1;
        run_until(8, 400, "b_timeout");
        for (int k = 0; k < 8; k++) begin
            check_output("b_order", at(obs_id, k), k % NREQ);
            check_output("b_data", at(obs_data, k), 32'h10 + (k % NREQ));
        end
        for (int k = 0; k < 4; k++)
            check_output("b_spacing", {31'b0, (at(obs_cyc, k + 4) - at(obs_cyc, k)) >= 4 * (BS + 2)}, 1);
        repeat (30) apply_stimulus();
        gate = '0;

        // busy held high 50 cycles after wr
        $display("[TB] long busy");
        clear_obs();
        auto_len = 50;
        q[0].push_back({1'b1, 8'h55});
        q[1].push_back({1'b1, 8'h66});
        gate = 4'b0011;
        run_until(2, 200, "c_timeout");
        check_output("c_order0", at(obs_id, 0), 0);
        check_output("c_order1", at(obs_id, 1), 1);
        check_output("c_gap", at(obs_cyc, 1) - at(obs_cyc, 0), 53);
        repeat (60) apply_stimulus();
        gate = '0;

        // reset during SETTLE
        $display("[TB] reset in settle");
        clear_obs();
        auto_len = 0;
        q[1].push_back({1'b1, 8'h77});
        gate[1] = 1'b1;
        run_until(1, 20, "d_timeout");
        apply_stimulus();
        drv_reset = 1'b1;
        apply_stimulus();
        check_output("d_wr", {31'b0, uart_wr}, 0);
        check_output("d_grant_id", {30'b0, grant_id}, 3);
        check_output("d_active", {31'b0, grant_active}, 0);
        drv_reset = 1'b0;
        clear_obs();
        q[0].push_back({1'b1, 8'h01});
        q[2].push_back({1'b1, 8'h02});
        gate = 4'b0101;
        run_until(1, 20, "d2_timeout");
        check_output("d_first", at(obs_id, 0), 0);
        repeat (20) apply_stimulus();
        gate = '0;

        // packet lock stimulus: requester 1 sends last=0,0,1 against requester 0
        $display("[TB] packet stimulus");
        pulse_reset();
        auto_len = 3;
        q[1].push_back({1'b0, 8'hA1});
        q[1].push_back({1'b0, 8'hA2});
        q[1].push_back({1'b1, 8'hA3});
        for (int i = 0; i < 3; i++) q[0].push_back({1'b1, 8'(8'hB1 + i)});
        gate = 4'b0010;
        run_until(1, 20, "e_timeout");
        gate = 4'b0011;
        run_until(6, 200, "e2_timeout");
        if (LOCK_EN) exp_seq = '{1, 1, 1, 0, 0, 0};
        else         exp_seq = '{1, 0, 1, 0, 1, 0};
        for (int k = 0; k < 6; k++) check_output("e_order", at(obs_id, k), exp_seq[k]);
        repeat (20) apply_stimulus();
        gate = '0;

        // busy never rises: back in IDLE BS+1 cycles after ISSUE
        $display("[TB] silent busy");
        clear_obs();
        auto_len = 0;
        q[3].push_back({1'b1, 8'hC3});
        gate[3] = 1'b1;
        run_until(1, 20, "f_timeout");
        for (int k = 0; k < BS; k++) begin
            apply_stimulus();
            check_output("f_hold", {31'b0, grant_active}, 1);
        end
        apply_stimulus();
        check_output("f_idle", {31'b0, grant_active}, 0);
        gate = '0;

        // randomized traffic, busy bursts and occasional resets
        $display("[TB] random traffic");
        rand_auto = 1'b1;
        begin
            int ext_left;
            ext_left = 0;
            for (int n = 0; n < 2500; n++) begin
                for (int i = 0; i < NREQ; i++) begin
                    if (q[i].size() < 3 && $urandom_range(0, 3) == 0) q[i].push_back(9'($urandom));
                    gate[i] = ($urandom_range(0, 9) < 7);
                end
                if (ext_left > 0) begin
                    ext_busy = 1'b1;
                    ext_left--;
                end else begin
                    ext_busy = 1'b0;
                    if ($urandom_range(0, 99) == 0) ext_left = $urandom_range(1, 15);
                end
                drv_reset = ($urandom_range(0, 399) == 0);
                apply_stimulus();
            end
        end
        drv_reset = 1'b0;
        ext_busy  = 1'b0;
        repeat (5) apply_stimulus();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/uart_tx_arbiter.md
# uart_tx_arbiter

Round-robin arbiter that shares one `buart` transmitter between `NUM_REQ` byte-stream requesters, such as a command-response engine, a debug printer and a status streamer. It accepts bytes over per-requester valid/ready handshakes and issues each byte as a single-cycle `wr` strobe to the UART. It then waits for the transmitter to finish before arbitrating again. The block sits between the peripheral logic and the `tx_data`/`wr`/`busy` side of `buart`.

## Interface
- `NUM_REQ`, default 4: number of requesters, 2..8.
- `ID_W`, default 2: grant index width; must satisfy 2^ID_W >= NUM_REQ.
- `BUSY_SETTLE`, default 2: cycles to wait after `wr` before sampling `uart_busy`, covering the `buart` busy-rise latency; range 1..15.

Ports:
- `clk`, in, 1: system clock. One clock domain.
- `reset`, in, 1: synchronous, active-high reset.
- `req_valid`, in, NUM_REQ: requester i has a byte.
- `req_data`, in, NUM_REQ*8: byte of requester i in bits [8i+7:8i]. Must be held stable while `req_valid[i]` is high and `req_ready[i]` is low.
- `req_last`, in, NUM_REQ: the byte is the last of a packet. Used only with the packet-lock feature.
- `req_ready`, out, NUM_REQ: byte accepted. One-hot, one-cycle pulse.
- `uart_wr`, out, 1: write strobe to `buart` `wr`.
- `uart_tx_data`, out, 8: byte to `buart` `tx_data`.
- `uart_busy`, in, 1: from `buart` `busy`.
- `grant_id`, out, ID_W: index of the current or last granted requester.
- `grant_active`, out, 1: high from ISSUE through DRAIN.

## Operation
- FSM states: IDLE, ISSUE, SETTLE, DRAIN.
- IDLE:
  - If no eligible `req_valid` bit is set, stay in IDLE.
  - Otherwise pick winner w by round-robin, starting the search at `grant_id+1` mod NUM_REQ.
  - Register `grant_id`<=w and `uart_tx_data`<=req_data[w], then go to ISSUE.
- ISSUE, exactly 1 cycle: `uart_wr`=1 and `req_ready[w]`=1; the handshake completes in this cycle. Go to SETTLE and load the settle counter with BUSY_SETTLE-1.
- SETTLE: decrement the counter while ignoring `uart_busy`. At zero, go to DRAIN.
- DRAIN: when `uart_busy`=0, return to IDLE. A transmitter that never raises busy still drains correctly.
- Outputs `uart_wr`, `req_ready` and `grant_active` are decoded from the state register only. There is no combinational path from any input to any output.
- `req_ready[i]` is never asserted unless `req_valid[i]` was high in the preceding IDLE cycle.
- A requester that deasserts `req_valid` while not yet granted simply loses that round. A requester that deasserts `req_valid` after being granted violates protocol; the byte is still sent.
- `uart_busy` high while in IDLE blocks arbitration: IDLE does not leave until busy is low. This protects an externally started transfer.

## Timing
- Reset values:
  - state=IDLE
  - `uart_wr`=0
  - `req_ready`=0
  - `uart_tx_data`=8'h00
  - `grant_id`=NUM_REQ-1, so requester 0 wins first
  - `grant_active`=0
  - lock released
- Latency: `req_valid` first seen high in IDLE at cycle k gives `uart_wr` and `req_ready` at cycle k+1.
- The earliest next grant is at 1+BUSY_SETTLE+1 cycles after ISSUE, provided busy is already low.
- Simultaneous requests: exactly one winner per round. With all NUM_REQ requesters valid, grants rotate 0,1,2,3,0...
- Pointer wrap: the search index wraps from NUM_REQ-1 to 0.
- Reset asserted in any state: the next edge returns to IDLE with outputs at their reset values. An in-flight UART byte is not aborted; the next IDLE waits for busy low.

## Configuration
- `UART_ARB_PKT_LOCK_EN` defined:
  - After a byte accepted with `req_last[w]`=0, the lock is set. While locked, IDLE considers only requester w and waits indefinitely for its `req_valid`.
  - A byte accepted with `req_last`=1 clears the lock.
  - Reset clears the lock.
- `UART_ARB_PKT_LOCK_EN` undefined:
  - `req_last` is ignored and every byte re-arbitrates.
  - No lock register is built.

## Structure
- A shared package `uart_arb_pkg` holds:
  - the FSM state encoding: IDLE=2'd0, ISSUE=2'd1, SETTLE=2'd2, DRAIN=2'd3
  - the settle counter width constant (4 bits)
- One sub-module, `rr_pick`: combinational round-robin selector. Inputs are the request vector and the last grant; outputs are the winner index and an `any` flag. It is reusable by the future RX dispatcher.

## Test plan
- Single requester, `req_valid[2]`=1, data 8'hAA, with the real `buart` at 115200 baud and 100 MHz: exactly one `uart_wr`, `req_ready[2]` in the same cycle, and 8'hAA decoded on `tx` by a loopback `buart` rx.
- All four requesters valid with bytes 8'h10..8'h13: transmitted order 10,11,12,13,10...; each requester's ready spacing is at least 4 transmit frames.
- Stub `uart_busy` held high for 50 cycles after `wr`: no second `uart_wr` until busy falls, then the next ISSUE occurs exactly 2 cycles later (IDLE, then ISSUE).
- Reset pulsed during SETTLE: next cycle `uart_wr`=0, `grant_id`=3; after release, requester 0 wins first.
- With `UART_ARB_PKT_LOCK_EN`: requester 1 sends 3 bytes with `req_last`=0,0,1 while requester 0 is continuously valid; the output is 1,1,1 and then 0. Without the macro, the same stimulus gives 1,0,1,0,1.
- Stub `busy` that never rises: the FSM still returns to IDLE BUSY_SETTLE+1 cycles after ISSUE.
